// File: rtl/cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cond_pkg
// Brief    : Shared types and constants for the ARMv4 execute-stage condition
//            unit: condition-field encoding and NZCV flag bit positions.
// Revision : 1.0 - initial release
// ============================================================================
package cond_pkg;

    // Width of the architectural NZCV flag register
    localparam int FLAGS_W = 4;

    // Bit positions of each flag inside the NZCV register
    localparam int FLAG_N  = 3;
    localparam int FLAG_Z  = 2;
    localparam int FLAG_C  = 1;
    localparam int FLAG_V  = 0;

    // ARM condition field encodings (instruction bits [31:28])
    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } condCode_t;

endpackage
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// ============================================================================
// Module   : cond_check
// Brief    : Purely combinational ARM condition evaluator. Compares a 4-bit
//            condition field against an NZCV flag vector and reports whether
//            the condition is met. Kept standalone so other front-end logic
//            (e.g. a branch predictor) can reuse it.
// Revision : 1.0 - initial release
// ============================================================================
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0]         cond,
    input  logic [FLAGS_W-1:0] flags,
    output logic               condMet
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    assign w_n = flags[FLAG_N];
    assign w_z = flags[FLAG_Z];
    assign w_c = flags[FLAG_C];
    assign w_v = flags[FLAG_V];

    // Decode the condition field against the supplied flags
    always_comb begin
        condMet = 1'b0;
        case (condCode_t'(cond))
            EQ:      condMet = w_z;
            NE:      condMet = ~w_z;
            CS:      condMet = w_c;
            CC:      condMet = ~w_c;
            MI:      condMet = w_n;
            PL:      condMet = ~w_n;
            VS:      condMet = w_v;
            VC:      condMet = ~w_v;
            HI:      condMet = w_c & ~w_z;
            LS:      condMet = ~w_c | w_z;
            GE:      condMet = (w_n == w_v);
            LT:      condMet = (w_n != w_v);
            GT:      condMet = ~w_z & (w_n == w_v);
            LE:      condMet = w_z | (w_n != w_v);
            AL:      condMet = 1'b1;
            NV:      condMet = 1'b0;
            default: condMet = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : cond_unit
// Brief    : Execute-stage condition unit for the ARMv4 core. Holds the NZCV
//            flag register, evaluates the instruction condition against the
//            current (pre-update) flags, gates the write-back / memory / PC
//            write controls and forms the execute/write-back pipeline register
//            with stall and flush.
//            Optional macro COND_UNIT_STATS_EN adds saturating 16-bit
//            executed/skipped instruction counters (execCount, skipCount).
// Revision : 1.0 - initial release
// ============================================================================
module cond_unit
    import cond_pkg::*;
#(
    parameter int                 N           = 32,
    parameter logic [FLAGS_W-1:0] RESET_FLAGS = 4'b0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inValid,
    input  logic               stall,
    input  logic               flush,
    input  logic [3:0]         cond,
    input  logic [FLAGS_W-1:0] aluFlags,
    input  logic [N-1:0]       aluResult,
    input  logic [1:0]         flagWrite,
    input  logic               pcSrc,
    input  logic               regWrite,
    input  logic               memWrite,
    output logic               outValid,
    output logic               condEx,
    output logic               pcSrcOut,
    output logic               regWriteOut,
    output logic               memWriteOut,
    output logic [N-1:0]       resultOut,
    output logic [FLAGS_W-1:0] flags
`ifdef COND_UNIT_STATS_EN
    ,
    output logic [15:0]        execCount,
    output logic [15:0]        skipCount
`endif
);

    logic               w_condMet;
    logic               w_pass;
    logic [FLAGS_W-1:0] w_nextFlags;

    logic               r_outValid;
    logic               r_condEx;
    logic               r_pcSrcOut;
    logic               r_regWriteOut;
    logic               r_memWriteOut;
    logic [N-1:0]       r_resultOut;
    logic [FLAGS_W-1:0] r_flags;

    // Condition is always judged on the architectural flags, never aluFlags,
    // so a flag-setting instruction only affects its successors.
    cond_check u_cond_check (
        .cond    (cond),
        .flags   (r_flags),
        .condMet (w_condMet)
    );

    assign w_pass = inValid & w_condMet;

    // Merge the ALU flags into NZCV under the per-group write enables
    always_comb begin
        w_nextFlags = r_flags;
        if (w_pass && flagWrite[1]) begin
            w_nextFlags[FLAG_N] = aluFlags[FLAG_N];
            w_nextFlags[FLAG_Z] = aluFlags[FLAG_Z];
        end
        if (w_pass && flagWrite[0]) begin
            w_nextFlags[FLAG_C] = aluFlags[FLAG_C];
            w_nextFlags[FLAG_V] = aluFlags[FLAG_V];
        end
    end

    // Pipeline register and flag register: reset > flush > stall > advance
    always_ff @(posedge clk) begin
        if (reset) begin
            r_outValid    <= 1'b0;
            r_condEx      <= 1'b0;
            r_pcSrcOut    <= 1'b0;
            r_regWriteOut <= 1'b0;
            r_memWriteOut <= 1'b0;
            r_resultOut   <= '0;
            r_flags       <= RESET_FLAGS;
        end else if (flush) begin
            // Flags hold: the killed instruction must not leave side effects
            r_outValid    <= 1'b0;
            r_condEx      <= 1'b0;
            r_pcSrcOut    <= 1'b0;
            r_regWriteOut <= 1'b0;
            r_memWriteOut <= 1'b0;
            r_resultOut   <= '0;
        end else if (!stall) begin
            // A failed condition retires as a valid bubble with no effects
            r_outValid    <= inValid;
            r_condEx      <= w_pass;
            r_pcSrcOut    <= pcSrc & w_pass;
            r_regWriteOut <= regWrite & w_pass;
            r_memWriteOut <= memWrite & w_pass;
            r_resultOut   <= aluResult;
            r_flags       <= w_nextFlags;
        end
    end

    assign outValid    = r_outValid;
    assign condEx      = r_condEx;
    assign pcSrcOut    = r_pcSrcOut;
    assign regWriteOut = r_regWriteOut;
    assign memWriteOut = r_memWriteOut;
    assign resultOut   = r_resultOut;
    assign flags       = r_flags;

`ifdef COND_UNIT_STATS_EN
    logic [15:0] r_execCount;
    logic [15:0] r_skipCount;

    // Saturating counts of executed vs condition-skipped instructions
    always_ff @(posedge clk) begin
        if (reset) begin
            r_execCount <= '0;
            r_skipCount <= '0;
        end else if (!flush && !stall && inValid) begin
            if (w_pass) begin
                if (r_execCount != 16'hFFFF) begin
                    r_execCount <= r_execCount + 16'd1;
                end
            end else begin
                if (r_skipCount != 16'hFFFF) begin
                    r_skipCount <= r_skipCount + 16'd1;
                end
            end
        end
    end

    assign execCount = r_execCount;
    assign skipCount = r_skipCount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_unit
// Brief    : Self-checking bench for cond_unit: directed vector table,
//            multi-cycle stall/flush sequences and randomized traffic against
//            a behavioural model of the condition rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cond_unit;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          inValid;
    logic          stall;
    logic          flush;
    logic [3:0]    cond;
    logic [3:0]    aluFlags;
    logic [N-1:0]  aluResult;
    logic [1:0]    flagWrite;
    logic          pcSrc;
    logic          regWrite;
    logic          memWrite;
    logic          outValid;
    logic          condEx;
    logic          pcSrcOut;
    logic          regWriteOut;
    logic          memWriteOut;
    logic [N-1:0]  resultOut;
    logic [3:0]    flags;
`ifdef COND_UNIT_STATS_EN
    logic [15:0]   execCount;
    logic [15:0]   skipCount;
`endif

    int checks   = 0;
    int failures = 0;

    // Model state
    logic [3:0]   m_flags;
    logic         m_valid, m_cond, m_pc, m_rw, m_mw;
    logic [N-1:0] m_res;
    int           m_exec, m_skip;

    cond_unit #(
        .N           (N),
        .RESET_FLAGS (4'b0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .inValid     (inValid),
        .stall       (stall),
        .flush       (flush),
        .cond        (cond),
        .aluFlags    (aluFlags),
        .aluResult   (aluResult),
        .flagWrite   (flagWrite),
        .pcSrc       (pcSrc),
        .regWrite    (regWrite),
        .memWrite    (memWrite),
        .outValid    (outValid),
        .condEx      (condEx),
        .pcSrcOut    (pcSrcOut),
        .regWriteOut (regWriteOut),
        .memWriteOut (memWriteOut),
        .resultOut   (resultOut),
        .flags       (flags)
`ifdef COND_UNIT_STATS_EN
        ,
        .execCount   (execCount),
        .skipCount   (skipCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         inValid, stall, flush;
        logic [3:0]   cond, aluFlags;
        logic [1:0]   fw;
        logic         pc, rw, mw;
        logic [N-1:0] res;
        logic         eValid, eCond, ePc, eRw, eMw;
        logic [N-1:0] eRes;
        logic [3:0]   eFlags;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic v, s, f, input logic [3:0] c, af, input logic [1:0] fw,
        input logic pc, rw, mw, input logic [N-1:0] res,
        input logic ev, ec, epc, erw, emw, input logic [N-1:0] eres,
        input logic [3:0] ef);
        vec_t t;
        t.inValid = v;  t.stall = s; t.flush = f; t.cond = c; t.aluFlags = af;
        t.fw = fw; t.pc = pc; t.rw = rw; t.mw = mw; t.res = res;
        t.eValid = ev; t.eCond = ec; t.ePc = epc; t.eRw = erw; t.eMw = emw;
        t.eRes = eres; t.eFlags = ef;
        return t;
    endfunction

    // Condition rule: codes pair up as (base, inverse) with odd codes negated;
    // 1110 always executes and 1111 never does.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c == 4'd15) return 1'b0;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, v, s, f, input logic [3:0] c, af,
                         input logic [1:0] fw, input logic pc, rw, mw,
                         input logic [N-1:0] res);
        @(negedge clk);
        reset = r; inValid = v; stall = s; flush = f; cond = c; aluFlags = af;
        flagWrite = fw; pcSrc = pc; regWrite = rw; memWrite = mw; aluResult = res;
        @(posedge clk);
        #1;
    endtask

    // Advance the model by one clock with the currently driven inputs
    task automatic model_step();
        logic p;
        if (reset) begin
            m_valid = 0; m_cond = 0; m_pc = 0; m_rw = 0; m_mw = 0; m_res = '0;
            m_flags = 4'b0000; m_exec = 0; m_skip = 0;
        end else if (flush) begin
            m_valid = 0; m_cond = 0; m_pc = 0; m_rw = 0; m_mw = 0; m_res = '0;
        end else if (!stall) begin
            p = inValid && ref_cond(cond, m_flags);
            m_valid = inValid; m_cond = p;
            m_pc = pcSrc && p; m_rw = regWrite && p; m_mw = memWrite && p;
            m_res = aluResult;
            if (inValid) begin
                if (p) m_exec = (m_exec < 65535) ? m_exec + 1 : m_exec;
                else   m_skip = (m_skip < 65535) ? m_skip + 1 : m_skip;
            end
            if (p && flagWrite[1]) m_flags[3:2] = aluFlags[3:2];
            if (p && flagWrite[0]) m_flags[1:0] = aluFlags[1:0];
        end
    endtask

    task automatic check_counts(input string tag);
`ifdef COND_UNIT_STATS_EN
        chk({tag, ".execCount"}, {16'd0, execCount}, m_exec[N-1:0]);
        chk({tag, ".skipCount"}, {16'd0, skipCount}, m_skip[N-1:0]);
`else
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    initial begin
        // Reset while driving an all-ones flag pattern: it must not leak in
        reset = 1; inValid = 1; stall = 0; flush = 0; cond = 4'b1110;
        aluFlags = 4'b1111; flagWrite = 2'b11; pcSrc = 1; regWrite = 1;
        memWrite = 1; aluResult = 32'hFFFF_FFFF;
        drive(1, 1, 0, 0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 32'hFFFF_FFFF);
        drive(1, 1, 1, 1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 32'hFFFF_FFFF);
        model_step();
        chk("rst.outValid", {31'd0, outValid}, 0);
        chk("rst.condEx", {31'd0, condEx}, 0);
        chk("rst.ctrl", {29'd0, pcSrcOut, regWriteOut, memWriteOut}, 0);
        chk("rst.resultOut", resultOut, 0);
        chk("rst.flags", {28'd0, flags}, 0);
        check_counts("rst");

        // Directed vectors, applied back to back (state carries over)
        vecs.push_back(mk(1,0,0, 4'b1110, 4'b0100, 2'b11, 0,1,0, 32'h1234,   1,1,0,1,0, 32'h1234, 4'b0100));
        vecs.push_back(mk(1,0,0, 4'b0001, 4'b1111, 2'b11, 1,1,1, 32'h55,     1,0,0,0,0, 32'h55,   4'b0100));
        vecs.push_back(mk(1,0,0, 4'b1110, 4'b0000, 2'b11, 0,0,0, 32'h0,      1,1,0,0,0, 32'h0,    4'b0000));
        vecs.push_back(mk(1,0,0, 4'b1110, 4'b1011, 2'b10, 0,0,0, 32'h7,      1,1,0,0,0, 32'h7,    4'b1000));
        vecs.push_back(mk(1,0,0, 4'b1110, 4'b0011, 2'b01, 1,1,1, 32'hA5,     1,1,1,1,1, 32'hA5,   4'b1011));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1,1,0, 4'b1110, 4'b0000, 2'b11, 0,1,0, 32'hDEAD, 1,1,1,1,1, 32'hA5, 4'b1011));
        vecs.push_back(mk(1,1,1, 4'b1110, 4'b0000, 2'b11, 1,1,1, 32'hBEEF,   0,0,0,0,0, 32'h0,    4'b1011));
        vecs.push_back(mk(1,0,0, 4'b1110, 4'b1001, 2'b11, 0,0,0, 32'h1,      1,1,0,0,0, 32'h1,    4'b1001));
        vecs.push_back(mk(1,0,0, 4'b1010, 4'b0110, 2'b00, 0,1,0, 32'h2,      1,1,0,1,0, 32'h2,    4'b1001));
        vecs.push_back(mk(1,0,0, 4'b1011, 4'b0110, 2'b11, 0,1,0, 32'h3,      1,0,0,0,0, 32'h3,    4'b1001));
        vecs.push_back(mk(1,0,0, 4'b1111, 4'b0110, 2'b11, 1,1,1, 32'h4,      1,0,0,0,0, 32'h4,    4'b1001));
        vecs.push_back(mk(0,0,0, 4'b1110, 4'b0000, 2'b11, 1,1,1, 32'h5,      0,0,0,0,0, 32'h5,    4'b1001));
        vecs.push_back(mk(1,0,1, 4'b1110, 4'b0110, 2'b11, 1,1,1, 32'h6,      0,0,0,0,0, 32'h0,    4'b1001));
        vecs.push_back(mk(1,0,0, 4'b1100, 4'b0000, 2'b00, 1,0,0, 32'h8,      1,1,1,0,0, 32'h8,    4'b1001));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(0, vecs[i].inValid, vecs[i].stall, vecs[i].flush, vecs[i].cond,
                  vecs[i].aluFlags, vecs[i].fw, vecs[i].pc, vecs[i].rw, vecs[i].mw, vecs[i].res);
            model_step();
            chk($sformatf("v%0d.outValid", i), {31'd0, outValid}, {31'd0, vecs[i].eValid});
            chk($sformatf("v%0d.condEx", i), {31'd0, condEx}, {31'd0, vecs[i].eCond});
            chk($sformatf("v%0d.ctrl", i), {29'd0, pcSrcOut, regWriteOut, memWriteOut},
                {29'd0, vecs[i].ePc, vecs[i].eRw, vecs[i].eMw});
            chk($sformatf("v%0d.resultOut", i), resultOut, vecs[i].eRes);
            chk($sformatf("v%0d.flags", i), {28'd0, flags}, {28'd0, vecs[i].eFlags});
            check_counts($sformatf("v%0d", i));
        end

        // Randomized traffic against the model, with occasional reset
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 63) == 0), 1'($urandom), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 9) == 0), 4'($urandom), 4'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), $urandom);
            model_step();
            chk("rnd.outValid", {31'd0, outValid}, {31'd0, m_valid});
            chk("rnd.condEx", {31'd0, condEx}, {31'd0, m_cond});
            chk("rnd.ctrl", {29'd0, pcSrcOut, regWriteOut, memWriteOut}, {29'd0, m_pc, m_rw, m_mw});
            chk("rnd.resultOut", resultOut, m_res);
            chk("rnd.flags", {28'd0, flags}, {28'd0, m_flags});
            check_counts("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Execute-stage condition unit for the ARMv4 core; the consumer end of the ALU result/flags path.
- Holds the architectural NZCV flag register and evaluates the 4-bit ARM condition field against it.
- Gates the instruction's write-back, memory-write and PC-write controls, and updates flags from the ALU's selected flags.
- All outputs are registered, forming the execute/write-back pipeline register with stall and flush.

Parameters:
N, 32, width of the ALU result carried to write-back
RESET_FLAGS, 4'b0000, NZCV value loaded on reset

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
inValid  in  1  execute-stage instruction present
stall  in  1  hold pipeline register and flags
flush  in  1  kill the execute-stage instruction
cond  in  4  instruction condition field [31:28]
aluFlags  in  4  ALU flags {N,Z,C,V} (bit3=N ... bit0=V)
aluResult  in  N  ALU result
flagWrite  in  2  [1] enables N,Z update; [0] enables C,V update
pcSrc  in  1  instruction writes PC
regWrite  in  1  instruction writes register file
memWrite  in  1  instruction writes memory
outValid  out  1  write-back-stage instruction valid
condEx  out  1  registered condition-passed result
pcSrcOut  out  1  gated pcSrc
regWriteOut  out  1  gated regWrite
memWriteOut  out  1  gated memWrite
resultOut  out  N  registered aluResult
flags  out  4  architectural NZCV register

Behaviour:
- Reset value of every output is 0, except flags=RESET_FLAGS. Reset overrides flush and stall.
- Priority: reset > flush > stall > normal.
- Condition evaluation is combinational on the current flags register, i.e. pre-update flags, never aluFlags:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL (1110) 1; NV (1111) 0
- Define pass = inValid & condMet.
- Normal cycle:
  - outValid<=inValid; condEx<=pass; resultOut<=aluResult.
  - pcSrcOut/regWriteOut/memWriteOut <= respective input & pass.
  - If pass: flags[3:2]<=aluFlags[3:2] when flagWrite[1]; flags[1:0]<=aluFlags[1:0] when flagWrite[0].
- Stall (no flush): every register, including flags, holds.
- Flush: outValid, condEx and the gated controls <=0; resultOut <=0; flags hold. Flush with stall is a flush.
- Latency is 1 cycle. Back-to-back flag-setting instructions need no bypass: the next instruction sees the updated flags.
- A failed condition still produces outValid=1 with condEx=0 and all gated controls 0, so it retires as a bubble.
- Controls with inValid=0 are ignored.

Optional Feature:
- Macro: COND_UNIT_STATS_EN.
- Enabled:
  - Adds outputs execCount[15:0] and skipCount[15:0], both reset to 0.
  - In each non-stalled, non-flushed cycle with inValid=1, increments execCount if pass, else skipCount.
  - Both counters saturate at 16'hFFFF.
- Disabled: the ports and counters do not exist.

Decomposition:
- Package cond_pkg:
  - enum condCode_t (EQ..NV, 4 bits)
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - localparam FLAGS_W=4
- Sub-module cond_check: purely combinational, takes cond and flags, returns condMet. Instantiated once; reusable by a future branch predictor.

Test Plan:
- Reset with flags input pattern 4'b1111, then release -> flags=4'b0000, all outputs 0.
- cond=AL, aluFlags=4'b0100, flagWrite=2'b11, regWrite=1, inValid=1 -> next cycle regWriteOut=1, condEx=1, flags=4'b0100.
- Flags=0100, cond=NE, regWrite=1, memWrite=1 -> outValid=1, condEx=0, regWriteOut=0, memWriteOut=0, flags unchanged.
- Flags=0000, cond=AL, aluFlags=1011, flagWrite=2'b10 -> flags=1000 (C,V kept 0). Then flagWrite=2'b01, aluFlags=0011 -> flags=1011.
- Stall held 3 cycles with cond=AL, flagWrite=11 -> outputs and flags frozen. Assert flush together with stall -> outValid=0 next edge, flags still frozen.
- Flags=1001 (N=V): cond=GE passes and cond=LT fails. cond=NV with regWrite=1 -> regWriteOut=0. With COND_UNIT_STATS_EN: execCount=1, skipCount=2.
